// File: rtl/bldc_commutator_pwm.sv
// rtl/bldc_commutator_pwm.sv - BLDC 6-step commutator with Hall debounce, soft-start PWM, dead-time and fault
// Drives three half-bridge phase codes from debounced Hall state, direction and ramped duty.
module bldc_commutator_pwm #(
    parameter int PWM_WIDTH    = 8,
    parameter int DEBOUNCE_CYC = 4,
    parameter int DEAD_CYC     = 8,
    parameter int RAMP_DIV     = 256,
    parameter int STALL_CYC    = 1000000,
    parameter int PER_WIDTH    = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 dir,
    input  logic [PWM_WIDTH-1:0] duty_cmd,
    input  logic [2:0]           hall,
    output logic [1:0]           a,
    output logic [1:0]           b,
    output logic [1:0]           c,
    output logic                 fault,
    output logic [PER_WIDTH-1:0] comm_period
);

    localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
    localparam int DTW = $clog2(DEAD_CYC + 1);
    localparam int RW  = $clog2(RAMP_DIV + 1);
    localparam int SW  = $clog2(STALL_CYC + 2);
    localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [DTW-1:0] DEAD_LOAD = DTW'(DEAD_CYC - 1);
    localparam logic [RW-1:0]  RAMP_MAX  = RW'(RAMP_DIV - 1);
    localparam logic [SW-1:0]  STALL_LIM = SW'(STALL_CYC);
    localparam logic [5:0]     FLOAT     = 6'b010101;

    typedef enum logic [1:0] {IDLE, RUN, DEAD, FAULT} state_t;

    state_t               state;
    logic [2:0]           hall_s1, hall_s2, hall_cand, hall_db, hall_prev, hall_run;
    logic [1:0]           sync_fill;
    logic [DBW-1:0]       db_cnt;
    logic                 db_valid;
    logic                 dir_run;
    logic [DTW-1:0]       dead_cnt;
    logic [PWM_WIDTH-1:0] duty_cur, duty_nxt, pwm_cnt;
    logic [RW-1:0]        ramp_cnt, ramp_nxt;
    logic [SW-1:0]        stall_cnt;
    logic [PER_WIDTH-1:0] per_cnt;
    logic [5:0]           abc;
    logic                 pwm_on, hall_bad, hall_chg, stall_hit, active, step_chg;

    assign {a, b, c}  = abc;
    assign pwm_on     = (pwm_cnt < duty_cur) || (&duty_cur);
    assign hall_bad   = (hall_db == 3'b000) || (hall_db == 3'b111);
    assign hall_chg   = (hall_db != hall_prev);
    assign stall_hit  = (STALL_CYC != 0) && (stall_cnt == STALL_LIM);
    assign active     = (state == RUN) || (state == DEAD);
    assign step_chg   = (hall_db != hall_run) || (dir != dir_run);

    // dir=0 swaps the roles of the switching (H) and sinking (L) phases
    function automatic logic [5:0] pattern(input logic [2:0] h, input logic d, input logic on);
        logic [1:0] ph, hi, lo;
        ph = on ? 2'b11 : 2'b01;
        hi = d ? ph : 2'b00;
        lo = d ? 2'b00 : ph;
        case (h)
            3'b001:  pattern = {lo, 2'b01, hi};
            3'b010:  pattern = {hi, lo, 2'b01};
            3'b011:  pattern = {2'b01, lo, hi};
            3'b100:  pattern = {2'b01, hi, lo};
            3'b101:  pattern = {lo, hi, 2'b01};
            3'b110:  pattern = {hi, 2'b01, lo};
            default: pattern = FLOAT;
        endcase
    endfunction

    always_comb begin
        duty_nxt = duty_cur;
        ramp_nxt = ramp_cnt;
        if (duty_cur > duty_cmd) begin
            duty_nxt = duty_cmd;
            ramp_nxt = '0;
        end else if (duty_cur < duty_cmd) begin
            if (ramp_cnt == RAMP_MAX) begin
                duty_nxt = duty_cur + 1'b1;
                ramp_nxt = '0;
            end else begin
                ramp_nxt = ramp_cnt + 1'b1;
            end
        end else begin
            ramp_nxt = '0;
        end
    end

    // Debounce only starts once the synchroniser holds real samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_s1   <= 3'b000;
            hall_s2   <= 3'b000;
            sync_fill <= 2'b00;
            hall_cand <= 3'b000;
            db_cnt    <= '0;
            hall_db   <= 3'b000;
            db_valid  <= 1'b0;
            hall_prev <= 3'b000;
        end else begin
            hall_s1   <= hall;
            hall_s2   <= hall_s1;
            sync_fill <= {sync_fill[0], 1'b1};
            hall_prev <= hall_db;
            if (sync_fill[1]) begin
                if (hall_s2 != hall_cand) begin
                    hall_cand <= hall_s2;
                    db_cnt    <= '0;
                end else if (db_cnt != DB_MAX) begin
                    db_cnt <= db_cnt + 1'b1;
                end else begin
                    hall_db  <= hall_cand;
                    db_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            abc         <= FLOAT;
            fault       <= 1'b0;
            comm_period <= '0;
            per_cnt     <= '0;
            stall_cnt   <= '0;
            duty_cur    <= '0;
            ramp_cnt    <= '0;
            pwm_cnt     <= '0;
            dead_cnt    <= '0;
            hall_run    <= 3'b000;
            dir_run     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;

            if (active) begin
                if (hall_chg) begin
                    stall_cnt   <= '0;
                    comm_period <= per_cnt;
                    per_cnt     <= PER_WIDTH'(1);
                end else begin
                    if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
                    if (per_cnt != '1)   per_cnt   <= per_cnt + 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end

            if (!enable) begin
                state    <= IDLE;
                abc      <= FLOAT;
                fault    <= 1'b0;
                duty_cur <= '0;
                ramp_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        abc      <= FLOAT;
                        duty_cur <= '0;
                        ramp_cnt <= '0;
                        if (db_valid) begin
                            if (hall_bad) begin
                                state <= FAULT;
                                fault <= 1'b1;
                            end else begin
                                state    <= RUN;
                                hall_run <= hall_db;
                                dir_run  <= dir;
                                abc      <= pattern(hall_db, dir, pwm_on);
                            end
                        end
                    end
                    RUN, DEAD: begin
                        duty_cur <= duty_nxt;
                        ramp_cnt <= ramp_nxt;
                        if (hall_bad || (state == RUN && stall_hit)) begin
                            state    <= FAULT;
                            fault    <= 1'b1;
                            abc      <= FLOAT;
                            duty_cur <= '0;
                            ramp_cnt <= '0;
                        end else if (step_chg) begin
                            state    <= DEAD;
                            dead_cnt <= DEAD_LOAD;
                            hall_run <= hall_db;
                            dir_run  <= dir;
                            abc      <= FLOAT;
                            if (dir != dir_run) begin
                                duty_cur <= '0;
                                ramp_cnt <= '0;
                            end
                        end else if (state == RUN) begin
                            abc <= pattern(hall_run, dir_run, pwm_on);
                        end else if (dead_cnt == '0) begin
                            state <= RUN;
                            abc   <= pattern(hall_run, dir_run, pwm_on);
                        end else begin
                            dead_cnt <= dead_cnt - 1'b1;
                            abc      <= FLOAT;
                        end
                    end
                    default: begin
                        abc      <= FLOAT;
                        fault    <= 1'b1;
                        duty_cur <= '0;
                        ramp_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bldc_commutator_pwm.sv
// tb/tb_bldc_commutator_pwm.sv - scoreboard bench for bldc_commutator_pwm
module tb_bldc_commutator_pwm;

    localparam int DEAD_CYC  = 8;
    localparam int STALL_CYC = 1000;

    logic        clk, rst_n, enable, dir;
    logic [7:0]  duty_cmd;
    logic [2:0]  hall;
    logic [1:0]  a, b, c;
    logic        fault;
    logic [19:0] comm_period;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [2:0] h;
        logic       d;
        bit         dead;
        bit         strict;
    } item_t;

    item_t q[$];

    bldc_commutator_pwm #(
        .PWM_WIDTH(8), .DEBOUNCE_CYC(4), .DEAD_CYC(DEAD_CYC),
        .RAMP_DIV(1), .STALL_CYC(STALL_CYC), .PER_WIDTH(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .dir(dir), .duty_cmd(duty_cmd),
        .hall(hall), .a(a), .b(b), .c(c), .fault(fault), .comm_period(comm_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Commutation roles straight from the phase table; dir=0 swaps H and L
    function automatic byte role(input logic [2:0] h, input logic d, input int p);
        string s;
        byte   r;
        case (h)
            3'd1:    s = "LFH";
            3'd2:    s = "HLF";
            3'd3:    s = "FLH";
            3'd4:    s = "FHL";
            3'd5:    s = "LHF";
            3'd6:    s = "HFL";
            default: s = "FFF";
        endcase
        r = s[p];
        if (!d) r = (r == "H") ? "L" : (r == "L") ? "H" : r;
        return r;
    endfunction

    function automatic int find_role(input logic [2:0] h, input logic d, input byte r);
        for (int p = 0; p < 3; p++) if (role(h, d, p) == r) return p;
        return 0;
    endfunction

    function automatic logic [1:0] pc(input int p);
        case (p)
            0:       return a;
            1:       return b;
            default: return c;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] h, input logic d, input bit dead, input bit strict);
        item_t it;
        it.h = h; it.d = d; it.dead = dead; it.strict = strict;
        q.push_back(it);
    endtask

    task automatic measure(input int hp, input int lp, output int on_cnt, output int lo_cnt);
        on_cnt = 0;
        lo_cnt = 0;
        repeat (256) begin
            @(negedge clk);
            if (pc(hp) == 2'b11) on_cnt++;
            if (pc(lp) == 2'b00) lo_cnt++;
        end
    endtask

    // Monitor: each float->driven transition is a commutation event
    bit    prev_float = 1'b1;
    int    float_run = 0;
    item_t mit;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_float = 1'b1;
            float_run  = 0;
        end else begin
            checks++;
            if (a == 2'b10 || b == 2'b10 || c == 2'b10) begin
                errors++;
                $display("FAIL code10: a=%b b=%b c=%b", a, b, c);
            end
            if ({a, b, c} == 6'b010101) begin
                float_run++;
                prev_float = 1'b1;
            end else begin
                if (prev_float) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_step: got a=%b b=%b c=%b with nothing expected", a, b, c);
                    end else begin
                        mit = q.pop_front();
                        for (int p = 0; p < 3; p++) begin
                            byte       r;
                            logic [1:0] v;
                            bit        ok;
                            r = role(mit.h, mit.d, p);
                            v = pc(p);
                            if (r == "L")      ok = (v == 2'b00);
                            else if (r == "F") ok = (v == 2'b01);
                            else if (mit.strict) ok = (v == 2'b11);
                            else               ok = (v == 2'b11 || v == 2'b01);
                            checks++;
                            if (!ok) begin
                                errors++;
                                $display("FAIL step_phase%0d: got %b required role %c (hall=%b dir=%b)",
                                         p, v, r, mit.h, mit.d);
                            end
                        end
                        if (mit.dead) begin
                            checks++;
                            if (float_run != DEAD_CYC) begin
                                errors++;
                                $display("FAIL dead_time: got %0d required %0d", float_run, DEAD_CYC);
                            end
                        end
                    end
                end
                float_run  = 0;
                prev_float = 1'b0;
            end
        end
    end

    initial begin
        logic [2:0] cur, nh, g;
        logic       d;
        int         t_prev, t_now, on_cnt, lo_cnt, n;
        logic [7:0] duty;

        rst_n = 1'b0; enable = 1'b1; dir = 1'b1; hall = 3'b001; duty_cmd = 8'hFF;
        cur = 3'b001; d = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_abc", {a, b, c}, 6'b010101);
        chk("rst_fault", fault, 0);
        chk("rst_period", comm_period, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(cur, d, 0, 0);

        tick(300);
        measure(find_role(cur, d, "H"), find_role(cur, d, "L"), on_cnt, lo_cnt);
        chk("full_duty_on", on_cnt, 256);
        chk("full_duty_low", lo_cnt, 256);

        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            do nh = 3'($urandom_range(1, 6)); while (nh == cur);
            hall = nh; cur = nh; t_now = cyc;
            push(cur, d, 1, 1);
            tick($urandom_range(60, 300));
            if (i > 0) chk("comm_period", comm_period, 32'(t_now - t_prev));
            t_prev = t_now;
        end

        dir = 1'b0; d = 1'b0;
        push(cur, d, 1, 0);
        tick(300);
        measure(find_role(cur, d, "H"), find_role(cur, d, "L"), on_cnt, lo_cnt);
        chk("dir0_duty_on", on_cnt, 256);
        chk("dir0_low", lo_cnt, 256);

        for (int k = 0; k < 3; k++) begin
            do nh = 3'($urandom_range(1, 6)); while (nh == cur);
            hall = nh; cur = nh;
            push(cur, d, 1, 0);
            duty = (k == 0) ? 8'h40 : 8'($urandom_range(1, 254));
            duty_cmd = duty;
            tick(290);
            measure(find_role(cur, d, "H"), find_role(cur, d, "L"), on_cnt, lo_cnt);
            chk("pwm_on_count", on_cnt, 32'(duty));
            chk("pwm_low_phase", lo_cnt, 256);
        end

        do g = 3'($urandom_range(1, 6)); while (g == cur);
        hall = g;
        tick(3);
        hall = cur;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if ({a, b, c} == 6'b010101) n++;
        end
        chk("glitch_float", n, 0);

        hall = 3'b111;
        tick(20);
        chk("badhall_fault", fault, 1);
        chk("badhall_abc", {a, b, c}, 6'b010101);
        enable = 1'b0;
        tick(1);
        @(negedge clk);
        chk("fault_clear", fault, 0);

        hall = 3'b010; cur = 3'b010;
        tick(20);
        push(cur, d, 0, 0);
        enable = 1'b1;
        n = 0;
        while (!fault && n < 1200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n < STALL_CYC || n > STALL_CYC + 5) begin
            errors++;
            $display("FAIL stall_time: got %0d cycles required %0d..%0d", n, STALL_CYC, STALL_CYC + 5);
        end
        chk("stall_abc", {a, b, c}, 6'b010101);
        enable = 1'b0;
        tick(2);

        push(cur, d, 0, 0);
        enable = 1'b1;
        tick(50);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_abc", {a, b, c}, 6'b010101);
        chk("async_rst_fault", fault, 0);
        chk("async_rst_period", comm_period, 0);
        enable = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        chk("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
